dfi_mem_responder: RTL
======================

Name: dfi_mem_responder

Overview:
- Synthesisable DFI-side memory emulator: the responder end of the DFI command/data interface driven by axi_ddr3_lite.
- Replaces generic_ddr3_phy plus the DDR3 device model in fast benches and FPGA loop-back builds.
- Decodes DDR3 commands, tracks open rows per bank, stores BL8 write bursts in an internal RAM, and returns read bursts with fixed latency.
- Flags protocol violations in a sticky error register.

Parameters:
- DDR_ROW_BITS, 13, row/addr bus width.
- DDR_COL_BITS, 10, column bits (units of 16-bit DDR beats).
- WIDTH, 32, DFI data width (two DDR beats per word).
- MEM_BITS, 10, log2 depth of internal word RAM.
- RD_LATENCY, 2, cycles from dfi_rden_i sample to dfi_rvld_o (range 1..8).
- QDEPTH, 4, pending-burst queue depth per direction (power of two).

Ports:
- clock  in  1  system clock (same clock as controller).
- reset  in  1  synchronous, active-high.
- dfi_rst_ni  in  1  DRAM reset, active low.
- dfi_cke_i  in  1  clock enable.
- dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni  in  1 each  command lines.
- dfi_odt_i  in  1  sampled, unused.
- dfi_bank_i  in  3  bank address.
- dfi_addr_i  in  DDR_ROW_BITS  row/column address; A10 = auto-precharge/all-banks.
- dfi_wstb_i  in  1  write preamble strobe, sampled, unused.
- dfi_wren_i  in  1  write-data word valid.
- dfi_mask_i  in  WIDTH/8  byte mask; 1 = byte NOT written.
- dfi_data_i  in  WIDTH  write data.
- dfi_rden_i  in  1  read-data word request.
- dfi_rvld_o  out  1  read data valid.
- dfi_data_o  out  WIDTH  read data.
- err_o  out  6  sticky error flags.

Behaviour:
- Reset, or dfi_rst_ni=0, or dfi_cke_i=0: all banks closed, both queues flushed, beat counters zero, read pipe cleared, dfi_rvld_o=0, dfi_data_o=0. err_o clears on reset only. RAM contents are preserved.
- Command decode applies only when cs_n=0, using {ras,cas,we}:
  - 011 ACT: open row dfi_addr_i in the bank.
  - 101 RD, 100 WR: push {bank, row, col} to the read or write queue. With A10=1, the bank closes after the push.
  - 010 PRE: close the bank, or all banks when A10=1.
  - 001 REF, 000 MRS: no state change.
  - 111 NOP: ignored.
  - cs_n=1 is NOP.
- Word address = {bank, open_row, col[CSB:3], beat[1:0]}, truncated to the low MEM_BITS bits.
- Write path: each dfi_wren_i cycle writes the head write-burst address at beat = wbeat, byte-wise per ~mask. wbeat increments 0..3; at beat 3 the write queue pops and wbeat wraps to 0.
- Read path: each dfi_rden_i cycle reads the head read-burst at rbeat, with the same counting and pop at beat 3. The data word is delayed so dfi_rvld_o/dfi_data_o appear exactly RD_LATENCY cycles after the rden sample. dfi_rvld_o follows rden one-for-one, with no bubbles inserted.
- Ordering: a WR command and a wren for an earlier burst may occur in the same cycle; the push and pop proceed together.
  - Read-after-write: a read whose rden follows the final wren cycle of a write returns the new data.
  - A same-cycle RAM write/read to one word returns the new data (write-first).
- err_o bits (each sticky):
  - [0] RD/WR to a closed bank.
  - [1] ACT to an already-open bank.
  - [2] col[2:0]≠0 on RD/WR.
  - [3] wren with an empty write queue; the data is dropped.
  - [4] rden with an empty read queue; returns data 0 with rvld still asserted.
  - [5] RD/WR pushed to a full queue; the command is dropped.
- Reset mid-burst: the partial burst is abandoned and no further rvld is produced, including words already in the pipe.

Decomposition:
- Package dfi_cmd_pkg:
  - command encodings (CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS, CMD_NOP);
  - err_o bit indices;
  - BL8 words-per-burst constant (4).
- Sub-module dfi_burst_queue: synchronous FIFO of {bank, row, col[CSB:3]}, with push/pop/flush/full/empty. Instantiated twice, once for reads and once for writes.

Test Plan:
- Reset → dfi_rvld_o=0, dfi_data_o=0, err_o=0.
- Write then read back:
  - Stimulus: ACT b0 r5; WR b0 c0; 4 wren with data 11111111, 22222222, 33333333, 44444444; RD b0 c0; 4 consecutive rden.
  - Response: rvld high 2 cycles after each rden, data in the same order; err_o=0.
- Byte mask: rewrite beat 1 with mask=4'b0101 and data AABBCCDD → readback of beat 1 = AA22CC22.
- Protocol errors:
  - RD b3 with no ACT → err_o[0]=1.
  - ACT b0 twice → err_o[1]=1.
  - rden with no RD queued → rvld with data 0 and err_o[4]=1.
- Queue behaviour:
  - Stimulus: 4 back-to-back RD (b0 c0, c8, c16, c24), then 16 rden.
  - Response: 16 contiguous rvld words in burst order. A fifth RD pushed while 4 are pending sets err_o[5].
- Reset mid-burst: reset after the 2nd rden → no rvld after reset deasserts; banks closed, so the next RD without ACT sets err_o[0].

Source files
------------

// File: rtl/dfi_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dfi_cmd_pkg
// Purpose  : Shared definitions for the DFI memory responder.
//            - DDR3 command encodings as {ras_n, cas_n, we_n}
//            - bit positions inside the sticky error register
//            - burst geometry constants
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dfi_cmd_pkg;

  // {ras_n, cas_n, we_n} with cs_n low. 3'b110 (ZQ) has no entry and is
  // treated like a NOP by the decoder.
  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_NOP = 3'b111
  } dfi_cmd_e;

  // Sticky error register bit positions
  localparam int ERR_CLOSED_BANK = 0;  // RD/WR to a bank with no open row
  localparam int ERR_ACT_OPEN    = 1;  // ACT to a bank that is already open
  localparam int ERR_COL_ALIGN   = 2;  // RD/WR column not BL8 aligned
  localparam int ERR_WR_EMPTY    = 3;  // write data with no write burst queued
  localparam int ERR_RD_EMPTY    = 4;  // read request with no read burst queued
  localparam int ERR_Q_FULL      = 5;  // RD/WR pushed into a full queue
  localparam int ERR_BITS        = 6;

  // A BL8 burst of 16-bit beats occupies four 32-bit DFI words
  localparam int BL8_WORDS = 4;

  // Address bit carrying auto-precharge (RD/WR) or all-banks (PRE)
  localparam int AP_BIT = 10;

endpackage : dfi_cmd_pkg
`default_nettype wire

// File: rtl/dfi_burst_queue.sv
`default_nettype none
// ============================================================================
// Module   : dfi_burst_queue
// Purpose  : Small synchronous FIFO of pending burst descriptors
//            {bank, row, col[CSB:3]}. One instance per direction.
// Ports    : clock      in   system clock
//            reset      in   synchronous active-high reset
//            flush      in   empties the queue (DRAM reset / CKE low)
//            push       in   write push_data (ignored when full)
//            push_data  in   ENTRY_W burst descriptor
//            pop        in   drop the head entry (ignored when empty)
//            head       out  oldest entry
//            full       out  DEPTH entries held
//            empty      out  no entries held
// Revision : 1.0 - initial release
// ============================================================================
module dfi_burst_queue #(
  parameter int ENTRY_W = 23,
  parameter int DEPTH   = 4     // power of two, at least 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] slots [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = slots[rd_ptr];

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) begin
      slots[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : dfi_burst_queue
`default_nettype wire

// File: rtl/dfi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dfi_mem_responder
// Purpose  : DFI-side DDR3 emulator. Decodes commands, tracks open rows per
//            bank, stores BL8 write bursts in an internal word RAM and
//            returns read bursts with a fixed latency. Protocol violations
//            set bits in a sticky error register.
// Ports    : clock                    in   system clock
//            reset                    in   synchronous active-high reset
//            dfi_rst_ni               in   DRAM reset, active low
//            dfi_cke_i                in   clock enable
//            dfi_cs_ni/ras/cas/we_ni  in   command lines
//            dfi_odt_i, dfi_wstb_i    in   sampled, unused
//            dfi_bank_i               in   bank address
//            dfi_addr_i               in   row/column address (A10 = AP/all)
//            dfi_wren_i               in   write data word valid
//            dfi_mask_i               in   byte mask, 1 = byte not written
//            dfi_data_i               in   write data word
//            dfi_rden_i               in   read data word request
//            dfi_rvld_o               out  read data valid
//            dfi_data_o               out  read data word (0 when not valid)
//            err_o                    out  sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module dfi_mem_responder
  import dfi_cmd_pkg::*;
#(
  parameter int DDR_ROW_BITS = 13,
  parameter int DDR_COL_BITS = 10,
  parameter int WIDTH        = 32,
  parameter int MEM_BITS     = 10,
  parameter int RD_LATENCY   = 2,
  parameter int QDEPTH       = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    dfi_rst_ni,
  input  logic                    dfi_cke_i,
  input  logic                    dfi_cs_ni,
  input  logic                    dfi_ras_ni,
  input  logic                    dfi_cas_ni,
  input  logic                    dfi_we_ni,
  input  logic                    dfi_odt_i,
  input  logic [2:0]              dfi_bank_i,
  input  logic [DDR_ROW_BITS-1:0] dfi_addr_i,
  input  logic                    dfi_wstb_i,
  input  logic                    dfi_wren_i,
  input  logic [WIDTH/8-1:0]      dfi_mask_i,
  input  logic [WIDTH-1:0]        dfi_data_i,
  input  logic                    dfi_rden_i,
  output logic                    dfi_rvld_o,
  output logic [WIDTH-1:0]        dfi_data_o,
  output logic [ERR_BITS-1:0]     err_o
);

  localparam int CSB       = DDR_COL_BITS - 1;
  localparam int CHI_W     = DDR_COL_BITS - 3;
  localparam int ENTRY_W   = 3 + DDR_ROW_BITS + CHI_W;
  localparam int BEAT_W    = $clog2(BL8_WORDS);
  localparam int FULL_W    = ENTRY_W + BEAT_W;
  localparam int MEM_DEPTH = 1 << MEM_BITS;
  localparam int NBYTES    = WIDTH / 8;

  // --------------------------------------------------------------------------
  // Command decode. Everything is held idle while the DRAM side is in reset
  // or clock-disabled; the error register keeps its value in that case.
  // --------------------------------------------------------------------------
  logic       flush;
  logic       cmd_live;
  logic [2:0] cmd_bits;
  logic       is_act, is_rd, is_wr, is_pre;
  logic       ap;

  assign flush    = reset | ~dfi_rst_ni | ~dfi_cke_i;
  assign cmd_live = ~flush & ~dfi_cs_ni;
  assign cmd_bits = {dfi_ras_ni, dfi_cas_ni, dfi_we_ni};
  assign is_act   = cmd_live && (cmd_bits == CMD_ACT);
  assign is_rd    = cmd_live && (cmd_bits == CMD_RD);
  assign is_wr    = cmd_live && (cmd_bits == CMD_WR);
  assign is_pre   = cmd_live && (cmd_bits == CMD_PRE);
  assign ap       = dfi_addr_i[AP_BIT];

  // --------------------------------------------------------------------------
  // Bank state
  // --------------------------------------------------------------------------
  logic [7:0]              bank_open;
  logic [DDR_ROW_BITS-1:0] open_row [8];

  always_ff @(posedge clock) begin
    if (flush) begin
      bank_open <= '0;
      for (int i = 0; i < 8; i++) open_row[i] <= '0;
    end else begin
      if (is_act) begin
        bank_open[dfi_bank_i] <= 1'b1;
        open_row[dfi_bank_i]  <= dfi_addr_i;
      end
      // Auto-precharge closes the bank even if the queue dropped the command
      if ((is_rd || is_wr) && ap) bank_open[dfi_bank_i] <= 1'b0;
      if (is_pre) begin
        if (ap) bank_open <= '0;
        else    bank_open[dfi_bank_i] <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Burst queues. A command to a closed bank is still queued (with whatever
  // row the bank last held) so that data-phase handshakes stay one-for-one.
  // --------------------------------------------------------------------------
  logic [ENTRY_W-1:0] new_entry;
  logic [ENTRY_W-1:0] rq_head, wq_head;
  logic               rq_full, rq_empty, wq_full, wq_empty;
  logic               rq_pop, wq_pop;
  logic               wr_go, rd_go;
  logic [BEAT_W-1:0]  wbeat, rbeat;

  assign new_entry = {dfi_bank_i, open_row[dfi_bank_i], dfi_addr_i[CSB:3]};

  dfi_burst_queue #(.ENTRY_W(ENTRY_W), .DEPTH(QDEPTH)) u_rd_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (is_rd),
    .push_data (new_entry),
    .pop       (rq_pop),
    .head      (rq_head),
    .full      (rq_full),
    .empty     (rq_empty)
  );

  dfi_burst_queue #(.ENTRY_W(ENTRY_W), .DEPTH(QDEPTH)) u_wr_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (is_wr),
    .push_data (new_entry),
    .pop       (wq_pop),
    .head      (wq_head),
    .full      (wq_full),
    .empty     (wq_empty)
  );

  assign wr_go  = ~flush & dfi_wren_i & ~wq_empty;
  assign rd_go  = ~flush & dfi_rden_i & ~rq_empty;
  assign wq_pop = wr_go && (wbeat == BEAT_W'(BL8_WORDS - 1));
  assign rq_pop = rd_go && (rbeat == BEAT_W'(BL8_WORDS - 1));

  // Beat counters wrap to 0 on the last word of each burst
  always_ff @(posedge clock) begin
    if (flush) begin
      wbeat <= '0;
      rbeat <= '0;
    end else begin
      if (wr_go) wbeat <= wbeat + BEAT_W'(1);
      if (rd_go) rbeat <= rbeat + BEAT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Word RAM. Addresses are the full {bank,row,col,beat} truncated to the
  // RAM depth, so distinct DRAM locations may alias.
  // --------------------------------------------------------------------------
  logic [FULL_W-1:0]   wfull_addr, rfull_addr;
  logic [MEM_BITS-1:0] waddr, raddr;
  logic [WIDTH-1:0]    ram [MEM_DEPTH];
  logic [WIDTH-1:0]    rd_word;

  assign wfull_addr = {wq_head, wbeat};
  assign rfull_addr = {rq_head, rbeat};
  assign waddr      = wfull_addr[MEM_BITS-1:0];
  assign raddr      = rfull_addr[MEM_BITS-1:0];

  always_ff @(posedge clock) begin
    if (wr_go) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (!dfi_mask_i[b]) ram[waddr][b*8 +: 8] <= dfi_data_i[b*8 +: 8];
      end
    end
  end

  // Write-first: a same-cycle write to the word being read is forwarded
  always_comb begin
    rd_word = ram[raddr];
    if (wr_go && (waddr == raddr)) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (!dfi_mask_i[b]) rd_word[b*8 +: 8] = dfi_data_i[b*8 +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read return pipe. Every rden produces exactly one valid word; an rden
  // with nothing queued returns zero. Flushing drops words in flight.
  // --------------------------------------------------------------------------
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [WIDTH-1:0]      dat_pipe [RD_LATENCY];

  always_ff @(posedge clock) begin
    if (flush) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= dfi_rden_i;
      dat_pipe[0] <= rd_go ? rd_word : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign dfi_rvld_o = vld_pipe[RD_LATENCY-1];
  assign dfi_data_o = dat_pipe[RD_LATENCY-1];

  // --------------------------------------------------------------------------
  // Sticky errors: cleared by the system reset only
  // --------------------------------------------------------------------------
  logic [ERR_BITS-1:0] err_flags;

  always_ff @(posedge clock) begin
    if (reset) begin
      err_flags <= '0;
    end else if (!flush) begin
      if ((is_rd || is_wr) && !bank_open[dfi_bank_i]) err_flags[ERR_CLOSED_BANK] <= 1'b1;
      if (is_act && bank_open[dfi_bank_i])             err_flags[ERR_ACT_OPEN]    <= 1'b1;
      if ((is_rd || is_wr) && (dfi_addr_i[2:0] != 3'b000))
        err_flags[ERR_COL_ALIGN] <= 1'b1;
      if (dfi_wren_i && wq_empty)                      err_flags[ERR_WR_EMPTY]    <= 1'b1;
      if (dfi_rden_i && rq_empty)                      err_flags[ERR_RD_EMPTY]    <= 1'b1;
      if ((is_rd && rq_full) || (is_wr && wq_full))    err_flags[ERR_Q_FULL]      <= 1'b1;
    end
  end

  assign err_o = err_flags;

  // Inputs carried for interface completeness and address bits lost to
  // RAM truncation.
  logic unused_bits;
  assign unused_bits = ^{dfi_odt_i, dfi_wstb_i,
                         wfull_addr[FULL_W-1:MEM_BITS], rfull_addr[FULL_W-1:MEM_BITS]};

endmodule : dfi_mem_responder
`default_nettype wire
